hilo_mdu: RTL and testbench
===========================

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, the EX-stage instruction has write_hilo=1 and is valid this cycle.
REQ-004 SHALL have port aluop, input, 8, operation code using the `EXE_*_OP` encodings of defines.vh.
REQ-005 SHALL have ports a and b, input, 32 each, rs and rt operand values.
REQ-006 SHALL have port flush, input, 1, kills the in-flight operation.
REQ-007 SHALL have port stall, output, 1, request to freeze the pipeline.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when HI/LO take a multicycle result.
REQ-009 SHALL have ports hi_o and lo_o, output, 32 each, registered HI and LO contents.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, DIV and FIN.
- IDLE: accept start.
- MUL and DIV: iterate.
- FIN: write the result.
REQ-011 SHALL, in IDLE with start=1 and aluop=`EXE_MTHI_OP` or `EXE_MTLO_OP`, write a into HI or LO at that edge, stay in IDLE, keep stall=0 and keep done=0.
REQ-012 SHALL, in IDLE with start=1 and aluop=`EXE_MULT_OP` or `EXE_MULTU_OP`, latch the operands, clear the iteration counter (5 bits) and enter MUL at the accept edge E0.
REQ-013 SHALL, for signed ops, latch the absolute values of the operands plus a result-negate flag equal to a[31]^b[31]; unsigned ops SHALL use the raw values.
REQ-014 SHALL perform one radix-2 shift-add step per edge in MUL (E1..E32) into a 64-bit accumulator, then move to FIN after the step at counter 31.
REQ-015 SHALL, at the FIN edge (E33), write the accumulator (two's-complement negated if the negate flag is set) as HI=[63:32] and LO=[31:0], assert done for the following cycle, and return to IDLE.
REQ-016 SHALL drive stall combinationally high when in IDLE with start=1 and a multicycle aluop, or when in any state other than IDLE; stall SHALL drop in the cycle done is high.
REQ-017 SHALL ignore start while not in IDLE (no re-latch, no second operation).
REQ-018 SHALL, on flush=1 in MUL, DIV or FIN, return to IDLE at the next edge with HI/LO unchanged and done=0; flush SHALL take priority over FIN writes and over new starts in the same cycle.
REQ-019 SHALL treat any other aluop with start=1 as a no-op.
REQ-020 SHALL keep hi_o/lo_o driven purely from registers, with no internal forwarding; MFHI/MFLO are read by EX from hi_o/lo_o.
REQ-021 SHALL overflow silently; MULTU 0xFFFFFFFF*0xFFFFFFFF SHALL yield the full 64-bit product.

Reset
REQ-022 SHALL, while resetn=0, asynchronously force state=IDLE, HI=0, LO=0, counter=0, done=0 and stall=0 (the start term is masked during reset).
REQ-023 SHALL make a reset asserted mid-operation discard that operation; after release the block SHALL be idle with HI=LO=0.

Configuration
REQ-024 SHALL use the macro HILO_MDU_DIV_EN to include or exclude the divider.
REQ-025 SHALL, with HILO_MDU_DIV_EN defined, accept `EXE_DIV_OP`/`EXE_DIVU_OP` into DIV.
- Runs 32 restoring-division steps (E1..E32), then FIN at E33.
- Writes LO=quotient, HI=remainder.
- Quotient negated if the operand signs differ (signed); remainder takes the dividend's sign.
REQ-026 SHALL, with HILO_MDU_DIV_EN defined and b=0, skip DIV: HI/LO unchanged, done pulsed after the accept edge, and stall=0 for that cycle.
REQ-027 SHALL, without HILO_MDU_DIV_EN, omit DIV-state logic and treat divide aluops as no-ops per REQ-019.

Verification
REQ-028 SHALL verify MULT: a=0xFFFFFFFE (-2), b=3 gives stall high for 34 cycles from accept, then HI=0xFFFFFFFF, LO=0xFFFFFFFA and done pulses once.
REQ-029 SHALL verify MULTU: a=b=0xFFFFFFFF gives HI=0xFFFFFFFE and LO=0x00000001 after E33.
REQ-030 SHALL verify MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on the next cycle: hi_o and lo_o show these values after each edge and stall never rises.
REQ-031 SHALL verify flush at E10 of MULT 5*7 with prior HI=0xA, LO=0xB: state is IDLE next cycle, HI=0xA, LO=0xB, no done pulse, and a second start asserted at E5 was ignored.
REQ-032 SHALL verify DIV with macro defined: a=0xFFFFFFF9 (-7), b=2 gives LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIV b=0 leaves HI/LO unchanged; without the macro, DIV never asserts stall.
REQ-033 SHALL verify reset: resetn pulled low at E20 of MULT gives immediate stall=0 and HI=LO=0, and after release a fresh MULT 3*4 gives LO=12.

Source files
------------

// File: rtl/hilo_mdu.sv
// HI/LO register pair with a multicycle radix-2 multiplier and optional restoring divider.
// The divider is built only when HILO_MDU_DIV_EN is defined; otherwise divide ops are no-ops.
module hilo_mdu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  aluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] hi_q, lo_q;
  logic [4:0]  cnt_q;
  logic        done_q;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] opb_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic        op_div_q;

  logic        is_mul, op_signed, div_go, multi;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_acc_d;
  logic [63:0] prod_d;
  logic [31:0] quot_d, rem_d;

  assign is_mul    = (aluop == EXE_MULT_OP) || (aluop == EXE_MULTU_OP);
  assign op_signed = (aluop == EXE_MULT_OP) || (aluop == EXE_DIV_OP);
  assign abs_a     = (op_signed && a[31]) ? (~a + 32'd1) : a;
  assign abs_b     = (op_signed && b[31]) ? (~b + 32'd1) : b;

`ifdef HILO_MDU_DIV_EN
  logic        is_div;
  logic [33:0] div_diff;
  logic [63:0] div_acc_d;

  assign is_div = (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  // A zero divisor completes in one cycle without touching HI/LO, so it never stalls.
  assign div_go = is_div && (b != 32'd0);

  // Restoring step on {remainder, dividend}: shift left one, try to subtract the divisor.
  assign div_diff  = {1'b0, acc_q[63:31]} - {2'b00, opb_q};
  assign div_acc_d = div_diff[33] ? {acc_q[62:0], 1'b0}
                                  : {div_diff[31:0], acc_q[30:0], 1'b1};
`else
  assign div_go = 1'b0;
`endif

  assign multi = is_mul || div_go;

  assign mul_acc_d = opb_q[0] ? (acc_q + mcand_q) : acc_q;
  assign prod_d    = neg_q_q ? (~acc_q + 64'd1) : acc_q;
  assign quot_d    = neg_q_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_d     = neg_r_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  assign stall = (state_q != S_IDLE) || (resetn && start && multi);
  assign done  = done_q;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      cnt_q    <= 5'd0;
      done_q   <= 1'b0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      opb_q    <= 32'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      op_div_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (aluop == EXE_MTHI_OP) begin
              hi_q <= a;
            end else if (aluop == EXE_MTLO_OP) begin
              lo_q <= a;
            end else if (is_mul) begin
              acc_q    <= 64'd0;
              mcand_q  <= {32'd0, abs_a};
              opb_q    <= abs_b;
              neg_q_q  <= op_signed && (a[31] ^ b[31]);
              neg_r_q  <= 1'b0;
              op_div_q <= 1'b0;
              cnt_q    <= 5'd0;
              state_q  <= S_MUL;
            end
`ifdef HILO_MDU_DIV_EN
            else if (is_div) begin
              if (b == 32'd0) begin
                done_q <= 1'b1;
              end else begin
                acc_q    <= {32'd0, abs_a};
                opb_q    <= abs_b;
                neg_q_q  <= op_signed && (a[31] ^ b[31]);
                neg_r_q  <= op_signed && a[31];
                op_div_q <= 1'b1;
                cnt_q    <= 5'd0;
                state_q  <= S_DIV;
              end
            end
`endif
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q   <= mul_acc_d;
            mcand_q <= {mcand_q[62:0], 1'b0};
            opb_q   <= {1'b0, opb_q[31:1]};
            cnt_q   <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_FIN;
          end
        end
`ifdef HILO_MDU_DIV_EN
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= div_acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_FIN;
          end
        end
`endif
        S_FIN: begin
          // A flush here drops the finished result entirely.
          if (!flush) begin
            if (op_div_q) begin
              hi_q <= rem_d;
              lo_q <= quot_d;
            end else begin
              hi_q <= prod_d[63:32];
              lo_q <= prod_d[31:0];
            end
            done_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu; divider checks follow HILO_MDU_DIV_EN.
module tb_hilo_mdu;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic        clk = 1'b0;
  logic        resetn, start, flush;
  logic [7:0]  aluop;
  logic [31:0] a, b;
  logic        stall, done;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  hilo_mdu dut (
    .clk(clk), .resetn(resetn), .start(start), .aluop(aluop), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] va, input logic [31:0] vb,
                        output int stall_n, output int done_n, output int done_at);
    stall_n = 0; done_n = 0; done_at = -1;
    aluop = op; a = va; b = vb; start = 1'b1;
    #1;
    if (stall) stall_n++;
    step();
    start = 1'b0; aluop = OP_NOP; a = '0; b = '0;
    for (int i = 0; i < 60; i++) begin
      if (stall) stall_n++;
      if (done) begin done_n++; done_at = i; end
      step();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; start = 1'b1; aluop = OP_MULT; a = 32'd5; b = 32'd5;
    #3;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi_o !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi_o); end
    n_cmp++; if (lo_o !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo_o); end
    start = 1'b0; aluop = OP_NOP;
    @(negedge clk);
    resetn = 1'b1;
    step();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL post_reset_stall got %b want 0", stall); end
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; aluop = OP_MTHI; a = 32'h1234_5678;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mthi_stall got %b want 0", stall); end
    step();
    n_cmp++; if (hi_o !== 32'h1234_5678) begin n_bad++; $display("FAIL mthi_hi got %h want 12345678", hi_o); end
    n_cmp++; if (lo_o !== 32'd0) begin n_bad++; $display("FAIL mthi_lo got %h want 0", lo_o); end
    aluop = OP_MTLO; a = 32'h9ABC_DEF0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mtlo_stall got %b want 0", stall); end
    step();
    start = 1'b0; aluop = OP_NOP;
    n_cmp++; if (lo_o !== 32'h9ABC_DEF0) begin n_bad++; $display("FAIL mtlo_lo got %h want 9abcdef0", lo_o); end
    n_cmp++; if (hi_o !== 32'h1234_5678) begin n_bad++; $display("FAIL mtlo_hi got %h want 12345678", hi_o); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mtlo_done got %b want 0", done); end
  endtask

  task automatic test_mult();
    int sn, dn, da;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, sn, dn, da);
    n_cmp++; if (sn != 34) begin n_bad++; $display("FAIL mult_stall_cycles got %0d want 34", sn); end
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL mult_done_count got %0d want 1", dn); end
    n_cmp++; if (da != 33) begin n_bad++; $display("FAIL mult_done_cycle got %0d want 33", da); end
    n_cmp++; if (hi_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", hi_o); end
    n_cmp++; if (lo_o !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL mult_lo got %h want fffffffa", lo_o); end
  endtask

  task automatic test_multu();
    int sn, dn, da;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sn, dn, da);
    n_cmp++; if (hi_o !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi got %h want fffffffe", hi_o); end
    n_cmp++; if (lo_o !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo got %h want 00000001", lo_o); end
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL multu_done_count got %0d want 1", dn); end
  endtask

  task automatic test_noop();
    start = 1'b1; aluop = OP_MFHI; a = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL noop_stall got %b want 0", stall); end
    step();
    start = 1'b0; aluop = OP_NOP;
    n_cmp++; if (hi_o !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL noop_hi got %h want fffffffe", hi_o); end
    n_cmp++; if (lo_o !== 32'h0000_0001) begin n_bad++; $display("FAIL noop_lo got %h want 00000001", lo_o); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL noop_done got %b want 0", done); end
  endtask

  task automatic test_flush();
    int sn, dn;
    start = 1'b1; aluop = OP_MTHI; a = 32'hA; step();
    aluop = OP_MTLO; a = 32'hB; step();
    aluop = OP_MULT; a = 32'd5; b = 32'd7; step();
    start = 1'b0; aluop = OP_NOP;
    repeat (4) step();
    start = 1'b1; aluop = OP_MULT; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0; aluop = OP_NOP;
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", stall); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_done got %b want 0", done); end
    n_cmp++; if (hi_o !== 32'hA) begin n_bad++; $display("FAIL flush_hi got %h want a", hi_o); end
    n_cmp++; if (lo_o !== 32'hB) begin n_bad++; $display("FAIL flush_lo got %h want b", lo_o); end
    sn = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (stall) sn++;
      if (done) dn++;
      step();
    end
    n_cmp++; if (sn != 0) begin n_bad++; $display("FAIL flush_later_stall got %0d want 0", sn); end
    n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL flush_later_done got %0d want 0", dn); end
    n_cmp++; if (lo_o !== 32'hB) begin n_bad++; $display("FAIL flush_later_lo got %h want b", lo_o); end
  endtask

  task automatic test_div();
    int sn, dn, da;
`ifdef HILO_MDU_DIV_EN
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, sn, dn, da);
    n_cmp++; if (lo_o !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", lo_o); end
    n_cmp++; if (hi_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", hi_o); end
    n_cmp++; if (sn != 34) begin n_bad++; $display("FAIL div_stall_cycles got %0d want 34", sn); end
    n_cmp++; if (da != 33) begin n_bad++; $display("FAIL div_done_cycle got %0d want 33", da); end
    run_op(OP_DIVU, 32'd100, 32'd7, sn, dn, da);
    n_cmp++; if (lo_o !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h want e", lo_o); end
    n_cmp++; if (hi_o !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h want 2", hi_o); end
    start = 1'b1; aluop = OP_DIV; a = 32'd5; b = 32'd0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL div0_stall got %b want 0", stall); end
    step();
    start = 1'b0; aluop = OP_NOP;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL div0_done got %b want 1", done); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL div0_stall_done got %b want 0", stall); end
    n_cmp++; if (lo_o !== 32'd14) begin n_bad++; $display("FAIL div0_lo got %h want e", lo_o); end
    n_cmp++; if (hi_o !== 32'd2) begin n_bad++; $display("FAIL div0_hi got %h want 2", hi_o); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL div0_done_width got %b want 0", done); end
`else
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, sn, dn, da);
    n_cmp++; if (sn != 0) begin n_bad++; $display("FAIL nodiv_stall got %0d want 0", sn); end
    n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL nodiv_done got %0d want 0", dn); end
    n_cmp++; if (hi_o !== 32'hA) begin n_bad++; $display("FAIL nodiv_hi got %h want a", hi_o); end
    n_cmp++; if (lo_o !== 32'hB) begin n_bad++; $display("FAIL nodiv_lo got %h want b", lo_o); end
    run_op(OP_DIVU, 32'd100, 32'd7, sn, dn, da);
    n_cmp++; if (sn != 0) begin n_bad++; $display("FAIL nodivu_stall got %0d want 0", sn); end
    n_cmp++; if (lo_o !== 32'hB) begin n_bad++; $display("FAIL nodivu_lo got %h want b", lo_o); end
`endif
  endtask

  task automatic test_back_to_back();
    int sn, dn, da;
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, sn, dn, da);
    n_cmp++; if (hi_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi got %h want ffffffff", hi_o); end
    n_cmp++; if (lo_o !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_neg_lo got %h want ffffffeb", lo_o); end
    start = 1'b1; aluop = OP_MULTU; a = 32'h0001_0000; b = 32'h0001_0000;
    step();
    start = 1'b0; aluop = OP_NOP;
    for (int i = 0; i < 50 && !done; i++) step();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_timeout got done=%b want 1", done); end
    n_cmp++; if (hi_o !== 32'd1) begin n_bad++; $display("FAIL b2b_first_hi got %h want 1", hi_o); end
    n_cmp++; if (lo_o !== 32'd0) begin n_bad++; $display("FAIL b2b_first_lo got %h want 0", lo_o); end
    start = 1'b1; aluop = OP_MULT; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_stall got %b want 1", stall); end
    step();
    start = 1'b0; aluop = OP_NOP;
    for (int i = 0; i < 50 && !done; i++) step();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_second_timeout got done=%b want 1", done); end
    n_cmp++; if (hi_o !== 32'd0) begin n_bad++; $display("FAIL b2b_second_hi got %h want 0", hi_o); end
    n_cmp++; if (lo_o !== 32'd1) begin n_bad++; $display("FAIL b2b_second_lo got %h want 1", lo_o); end
    step();
  endtask

  task automatic test_reset_mid();
    int sn, dn, da;
    start = 1'b1; aluop = OP_MTHI; a = 32'h55; step();
    aluop = OP_MTLO; a = 32'h66; step();
    aluop = OP_MULT; a = 32'h1234; b = 32'h10; step();
    start = 1'b0; aluop = OP_NOP;
    repeat (19) step();
    @(posedge clk);
    resetn = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall got %b want 0", stall); end
    n_cmp++; if (hi_o !== 32'd0) begin n_bad++; $display("FAIL midrst_hi got %h want 0", hi_o); end
    n_cmp++; if (lo_o !== 32'd0) begin n_bad++; $display("FAIL midrst_lo got %h want 0", lo_o); end
    @(negedge clk);
    resetn = 1'b1;
    step();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midrst_idle_stall got %b want 0", stall); end
    run_op(OP_MULT, 32'd3, 32'd4, sn, dn, da);
    n_cmp++; if (lo_o !== 32'd12) begin n_bad++; $display("FAIL midrst_mult_lo got %h want c", lo_o); end
    n_cmp++; if (hi_o !== 32'd0) begin n_bad++; $display("FAIL midrst_mult_hi got %h want 0", hi_o); end
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL midrst_mult_done got %0d want 1", dn); end
  endtask

  initial begin
    start = 1'b0; flush = 1'b0; aluop = OP_NOP; a = '0; b = '0; resetn = 1'b0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_multu();
    test_noop();
    test_flush();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
